// File: rtl/regfile_writeback_ctrl_pkg.sv
// rtl/regfile_writeback_ctrl_pkg.sv - shared register-file constants and result record
package regfile_writeback_ctrl_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 2;
  localparam int NUM_REGS   = 2 ** ADDR_W;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 2;

  // One buffered write-back: destination register and its value.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_result_t;

endpackage

// File: rtl/regfile_writeback_ctrl_fifo.sv
// rtl/regfile_writeback_ctrl_fifo.sv - synchronous result FIFO with simultaneous push/pop
module wb_result_fifo
  import regfile_writeback_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  wb_result_t push_rec,
  input  logic       pop,
  output wb_result_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_result_t       mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; a full FIFO refuses pushes even when popping this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= push_rec;
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// rtl/regfile_writeback_ctrl.sv - ALU/load write-back arbiter, drain and pending-write scoreboard
module regfile_writeback_ctrl
  import regfile_writeback_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_dest,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [ADDR_W-1:0]   mem_dest,
  input  logic [DATA_W-1:0]   mem_data,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_dest,
  output logic                issue_stall,
  output logic [NUM_REGS-1:0] pending,
  output logic                write_en,
  output logic [ADDR_W-1:0]   write_sel,
  output logic [DATA_W-1:0]   write_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  wb_result_t       push_rec;
  wb_result_t       head;

  logic [CNT_W-1:0]    cnt      [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                inc_ok;

  // Loads win over the ALU; readiness never looks at the same source's valid.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push      = (mem_valid || alu_valid) && !full;
  assign pop       = !empty;

  // Select the record offered to the FIFO this cycle.
  always_comb begin
    push_rec = '{dest: alu_dest, data: alu_data};
    if (mem_valid) push_rec = '{dest: mem_dest, data: mem_data};
  end

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // Drain one buffered result per cycle onto the register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en   <= 1'b0;
      write_sel  <= '0;
      write_data <= '0;
    end else begin
      write_en <= pop;
      if (pop) begin
        write_sel  <= head.dest;
        write_data <= head.data;
      end
    end
  end

  assign issue_stall = issue_valid && (cnt[issue_dest] == CNT_MAX);
  assign inc_ok      = issue_valid && !issue_stall;

  // Per-register next count: issue adds, a completed write removes, both cancel.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_next[r] = cnt[r];
      inc_vec[r]  = inc_ok && (issue_dest == ADDR_W'(r));
      dec_vec[r]  = write_en && (write_sel == ADDR_W'(r)) && (cnt[r] != '0);
      if (inc_vec[r] && !dec_vec[r])      cnt_next[r] = cnt[r] + CNT_W'(1);
      else if (dec_vec[r] && !inc_vec[r]) cnt_next[r] = cnt[r] - CNT_W'(1);
    end
  end

  // Scoreboard counters and the registered pending flags derived from them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      pending <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r]     <= cnt_next[r];
        pending[r] <= (cnt_next[r] != '0);
      end
    end
  end

  // A write to a register with nothing outstanding means decode and producers disagree.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(write_en && (cnt[write_sel] == '0) && !(inc_ok && (issue_dest == write_sel))));

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// tb/tb_regfile_writeback_ctrl.sv - randomized self-checking bench for regfile_writeback_ctrl
module tb_regfile_writeback_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alu_valid, alu_ready, mem_valid, mem_ready;
  logic [1:0] alu_dest, mem_dest, issue_dest, write_sel;
  logic [7:0] alu_data, mem_data, write_data;
  logic       issue_valid, issue_stall, write_en;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] dest;
    logic [7:0] data;
  } rec_t;

  rec_t       q[$];
  int         cnt[4];
  int         owed[4];
  bit         m_we;
  logic [1:0] m_sel;
  logic [7:0] m_data;
  logic [7:0] rf_dut[4];
  logic [7:0] rf_ref[4];

  regfile_writeback_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_stall(issue_stall),
    .pending(pending), .write_en(write_en), .write_sel(write_sel), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 4; r++) begin
      cnt[r] = 0; owed[r] = 0; rf_dut[r] = 8'h00; rf_ref[r] = 8'h00;
    end
    m_we = 0; m_sel = 2'd0; m_data = 8'h00;
  endtask

  task automatic drive(input bit av, input logic [1:0] ad, input logic [7:0] adat,
                       input bit mv, input logic [1:0] md, input logic [7:0] mdat,
                       input bit iv, input logic [1:0] idst);
    alu_valid = av; alu_dest = ad; alu_data = adat;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    issue_valid = iv; issue_dest = idst;
  endtask

  task automatic drive_idle();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 0, 2'd0);
  endtask

  // One clock: check handshakes before the edge, advance the model, check registered outputs after.
  task automatic step();
    bit full, exp_ar, exp_mr, exp_st;
    rec_t r;
    logic [3:0] ep;
    full   = (q.size() == 4);
    exp_mr = !full;
    exp_ar = !full && !mem_valid;
    exp_st = issue_valid && (cnt[issue_dest] == 3);
    #1;
    checks++; if (alu_ready !== exp_ar) begin errors++; $display("FAIL alu_ready got %0b want %0b", alu_ready, exp_ar); end
    checks++; if (mem_ready !== exp_mr) begin errors++; $display("FAIL mem_ready got %0b want %0b", mem_ready, exp_mr); end
    checks++; if (issue_stall !== exp_st) begin errors++; $display("FAIL issue_stall got %0b want %0b", issue_stall, exp_st); end
    @(posedge clk);
    if (m_we && cnt[m_sel] > 0) cnt[m_sel]--;
    if (issue_valid && !exp_st) begin cnt[issue_dest]++; owed[issue_dest]++; end
    if (q.size() > 0) begin
      r = q.pop_front();
      m_we = 1; m_sel = r.dest; m_data = r.data; rf_ref[r.dest] = r.data;
    end else begin
      m_we = 0;
    end
    if (mem_valid && exp_mr) begin
      r.dest = mem_dest; r.data = mem_data; q.push_back(r); owed[mem_dest]--;
    end else if (alu_valid && exp_ar) begin
      r.dest = alu_dest; r.data = alu_data; q.push_back(r); owed[alu_dest]--;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) ep[i] = (cnt[i] != 0);
    checks++; if (write_en !== m_we) begin errors++; $display("FAIL write_en got %0b want %0b", write_en, m_we); end
    checks++; if (write_sel !== m_sel) begin errors++; $display("FAIL write_sel got %0d want %0d", write_sel, m_sel); end
    checks++; if (write_data !== m_data) begin errors++; $display("FAIL write_data got %h want %h", write_data, m_data); end
    checks++; if (pending !== ep) begin errors++; $display("FAIL pending got %b want %b", pending, ep); end
    if (write_en === 1'b1) rf_dut[write_sel] = write_data;
  endtask

  task automatic flush();
    drive_idle();
    for (int r = 0; r < 4; r++) begin
      while (owed[r] > 0) begin
        drive(1, 2'(r), 8'($urandom_range(0, 255)), 0, 2'd0, 8'h00, 0, 2'd0);
        step();
      end
    end
    drive_idle();
    repeat (3) step();
  endtask

  task automatic test_regfile_contents(input string tag);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (rf_dut[r] !== rf_ref[r]) begin
        errors++; $display("FAIL regfile_%s[%0d] got %h want %h", tag, r, rf_dut[r], rf_ref[r]);
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rst_write_en got %0b want 0", write_en); end
    checks++; if (write_sel !== 2'd0 || write_data !== 8'h00) begin errors++; $display("FAIL rst_write_bus got %0d/%h want 0/00", write_sel, write_data); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rst_pending got %b want 0000", pending); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b%0b want 11", alu_ready, mem_ready); end
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_single_alu();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd2); step();
    drive_idle(); step();
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL single_pending_issued got %0b want 1", pending[2]); end
    drive(1, 2'd2, 8'hA5, 0, 2'd0, 8'h00, 0, 2'd0); step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL single_early got %0b want 0", write_en); end
    drive_idle(); step();
    checks++; if (write_en !== 1'b1 || write_sel !== 2'd2 || write_data !== 8'hA5) begin
      errors++; $display("FAIL single_write got %0b/%0d/%h want 1/2/a5", write_en, write_sel, write_data);
    end
    checks++; if (pending[2] !== 1'b1) begin errors++; $display("FAIL single_pending_during got %0b want 1", pending[2]); end
    step();
    checks++; if (write_en !== 1'b0 || pending[2] !== 1'b0) begin
      errors++; $display("FAIL single_after got we=%0b pend=%0b want 0/0", write_en, pending[2]);
    end
    test_regfile_contents("single");
  endtask

  task automatic test_contention();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd1); step();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd3); step();
    drive(1, 2'd1, 8'h11, 1, 2'd3, 8'h33, 0, 2'd0);
    #1;
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
      errors++; $display("FAIL contention_ready got alu=%0b mem=%0b want 0/1", alu_ready, mem_ready);
    end
    step();
    drive(1, 2'd1, 8'h11, 0, 2'd0, 8'h00, 0, 2'd0); step();
    checks++; if (write_en !== 1'b1 || write_sel !== 2'd3 || write_data !== 8'h33) begin
      errors++; $display("FAIL contention_first got %0b/%0d/%h want 1/3/33", write_en, write_sel, write_data);
    end
    drive_idle(); step();
    checks++; if (write_en !== 1'b1 || write_sel !== 2'd1 || write_data !== 8'h11) begin
      errors++; $display("FAIL contention_second got %0b/%0d/%h want 1/1/11", write_en, write_sel, write_data);
    end
    step();
    test_regfile_contents("contention");
  endtask

  task automatic test_saturation();
    repeat (3) begin drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0); step(); end
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0);
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL sat_stall got %0b want 1", issue_stall); end
    step();
    drive(1, 2'd0, 8'h77, 0, 2'd0, 8'h00, 0, 2'd0); step();
    drive_idle(); step();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0);
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL sat_stall_with_write got %0b want 1", issue_stall); end
    step();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0);
    #1;
    checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL sat_released got %0b want 0", issue_stall); end
    step();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd0);
    #1;
    checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL sat_again got %0b want 1", issue_stall); end
    step();
    flush();
  endtask

  task automatic test_back_to_back();
    int wcount = 0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'(i % 4)); step();
    end
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(0, 2'd0, 8'h00, 1, 2'(i % 4), 8'($urandom_range(0, 255)), 0, 2'd0);
      else            drive(1, 2'(i % 4), 8'($urandom_range(0, 255)), 0, 2'd0, 8'h00, 0, 2'd0);
      step();
      if (i > 0 && write_en === 1'b1) wcount++;
    end
    drive_idle(); step();
    if (write_en === 1'b1) wcount++;
    checks++; if (wcount !== 8) begin errors++; $display("FAIL b2b_writes got %0d want 8", wcount); end
    repeat (2) step();
    test_regfile_contents("b2b");
  endtask

  task automatic test_random();
    int cand[$];
    bit mv, av;
    logic [1:0] md, ad;
    for (int n = 0; n < 300; n++) begin
      cand.delete();
      for (int r = 0; r < 4; r++) if (owed[r] > 0) cand.push_back(r);
      mv = (cand.size() > 0) && ($urandom_range(0, 2) == 0);
      av = (cand.size() > 0) && ($urandom_range(0, 1) == 0);
      md = (cand.size() > 0) ? 2'(cand[$urandom_range(0, cand.size() - 1)]) : 2'd0;
      ad = (cand.size() > 0) ? 2'(cand[$urandom_range(0, cand.size() - 1)]) : 2'd0;
      drive(av, ad, 8'($urandom_range(0, 255)), mv, md, 8'($urandom_range(0, 255)),
            bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      step();
    end
    flush();
    test_regfile_contents("random");
  endtask

  task automatic test_reset_mid();
    drive(0, 2'd0, 8'h00, 0, 2'd0, 8'h00, 1, 2'd1); step();
    step();
    drive(1, 2'd1, 8'h5A, 0, 2'd0, 8'h00, 0, 2'd0); step();
    drive(0, 2'd0, 8'h00, 1, 2'd1, 8'hC3, 0, 2'd0); step();
    drive_idle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mid_rst_write_en got %0b want 0", write_en); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL mid_rst_pending got %b want 0000", pending); end
    checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || issue_stall !== 1'b0) begin
      errors++; $display("FAIL mid_rst_handshake got %0b%0b%0b want 110", alu_ready, mem_ready, issue_stall);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mid_rst_late_write cycle %0d got %0b want 0", i, write_en); end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_saturation();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
